vsmac_seq_ctrl: RTL and testbench

Sequencer for one vsmac vector-scalar MAC array. On a start request it clears the array, then fetches ACCUMULATIONS operand beats (a vector plus b scalar) from a simple request/valid operand memory. It issues each beat to the array as a one-cycle enable, waits for the array's output register to settle, and presents the result vector on a valid/ready port. One controller sits beside each vsmac instance in the accelerator datapath.

---
 rtl/vsmac_seq_ctrl_if.sv | 43 ++++
 rtl/vsmac_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_vsmac_seq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vsmac_seq_ctrl_if.sv
// ============================================================================
// vsmac_seq_ctrl_if : start / operand-read / MAC / result bundle for vsmac_seq_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

interface vsmac_seq_ctrl_if #(
   parameter int SIZE       = 6,
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 8
);
   logic                     start;
   logic [ADDR_WIDTH-1:0]    base_addr;
   logic                     busy;
   logic                     done;
   logic                     rd_en;
   logic [ADDR_WIDTH-1:0]    rd_addr;
   logic                     rd_valid;
   logic [WIDTH*SIZE-1:0]    rd_a;
   logic [WIDTH-1:0]         rd_b;
   logic                     mac_clear;
   logic                     mac_enable;
   logic [WIDTH*SIZE-1:0]    mac_a;
   logic [WIDTH-1:0]         mac_b;
   logic [WIDTH*SIZE-1:0]    mac_out;
   logic                     res_valid;
   logic                     res_ready;
   logic [WIDTH*SIZE-1:0]    res_data;

   modport master (
      input  start, base_addr, rd_valid, rd_a, rd_b, mac_out, res_ready,
      output busy, done, rd_en, rd_addr, mac_clear, mac_enable, mac_a, mac_b,
             res_valid, res_data
   );

   modport slave (
      output start, base_addr, rd_valid, rd_a, rd_b, mac_out, res_ready,
      input  busy, done, rd_en, rd_addr, mac_clear, mac_enable, mac_a, mac_b,
             res_valid, res_data
   );
endinterface

`default_nettype wire

// File: rtl/vsmac_seq_ctrl.sv
// ============================================================================
// vsmac_seq_ctrl : job sequencer for one vsmac array; optional VSMAC_CTRL_STALL_CNT_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module vsmac_seq_ctrl #(
   parameter int SIZE          = 6,
   parameter int WIDTH         = 8,
   parameter int ACCUMULATIONS = 3,
   parameter int ADDR_WIDTH    = 8,
   parameter int SETTLE_CYCLES = 2
) (
   input  wire              clk,
   input  wire              reset,
`ifdef VSMAC_CTRL_STALL_CNT_EN
   output logic [15:0]      stall_cycles,
`endif
   vsmac_seq_ctrl_if.master bus
);
   localparam int KW = $clog2(ACCUMULATIONS + 1);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      FETCH  = 3'd2,
      ISSUE  = 3'd3,
      SETTLE = 3'd4,
      RESULT = 3'd5
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [KW-1:0]           k;
   logic [SW-1:0]           settle_cnt;
   logic [ADDR_WIDTH-1:0]   base;
   logic [WIDTH*SIZE-1:0]   a_q;
   logic [WIDTH-1:0]        b_q;
   logic [WIDTH*SIZE-1:0]   res_q;
   logic                    done_q;
   logic                    accept;
   logic                    last_beat;
   logic                    last_settle;

   assign accept      = (state == IDLE) && bus.start;
   assign last_beat   = (k == KW'(ACCUMULATIONS - 1));
   assign last_settle = (settle_cnt == SW'(SETTLE_CYCLES - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start)     state_nxt = CLEAR;
         CLEAR:                      state_nxt = FETCH;
         FETCH:   if (bus.rd_valid)  state_nxt = ISSUE;
         ISSUE:                      state_nxt = last_beat ? SETTLE : FETCH;
         SETTLE:  if (last_settle)   state_nxt = RESULT;
         RESULT:  if (bus.res_ready) state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         k          <= '0;
         settle_cnt <= '0;
         base       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         res_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= (state == RESULT) && bus.res_ready;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  base <= bus.base_addr;
                  k    <= '0;
               end
            end
            FETCH: begin
               if (bus.rd_valid) begin
                  a_q <= bus.rd_a;
                  b_q <= bus.rd_b;
               end
            end
            ISSUE: begin
               k          <= k + 1'b1;
               settle_cnt <= '0;
            end
            SETTLE: begin
               settle_cnt <= settle_cnt + 1'b1;
               // the array's output register moved on the falling edge, so mac_out is final here
               if (last_settle) res_q <= bus.mac_out;
            end
            default: ;
         endcase
      end
   end

`ifdef VSMAC_CTRL_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (accept) begin
         stall_cycles <= '0;
      end else if ((state == FETCH) && !bus.rd_valid && (stall_cycles != 16'hFFFF)) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end
`endif

   assign bus.busy       = (state != IDLE);
   assign bus.done       = done_q;
   assign bus.rd_en      = (state == FETCH);
   assign bus.rd_addr    = base + ADDR_WIDTH'(k);
   assign bus.mac_clear  = reset || (state == CLEAR);
   assign bus.mac_enable = (state == ISSUE);
   assign bus.mac_a      = a_q;
   assign bus.mac_b      = b_q;
   assign bus.res_valid  = (state == RESULT);
   assign bus.res_data   = res_q;

endmodule

`default_nettype wire

// File: tb/tb_vsmac_seq_ctrl.sv
// ============================================================================
// tb_vsmac_seq_ctrl : directed self-checking bench for vsmac_seq_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vsmac_seq_ctrl;
   localparam int SZ = 6;
   localparam int W  = 8;
   localparam int AW = 8;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;
   int   lat;
   int   wcnt;
   int   n_en;
   int   n_dbl;
   int   n_addr;
   logic en_prev;
   logic [AW-1:0]   addr_log [64];
   logic [W*SZ-1:0] acc;
`ifdef VSMAC_CTRL_STALL_CNT_EN
   logic [15:0] stall_cycles;
`endif

   vsmac_seq_ctrl_if #(.SIZE(SZ), .WIDTH(W), .ADDR_WIDTH(AW)) bus ();

   vsmac_seq_ctrl #(
      .SIZE(SZ), .WIDTH(W), .ACCUMULATIONS(3), .ADDR_WIDTH(AW), .SETTLE_CYCLES(2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
`ifdef VSMAC_CTRL_STALL_CNT_EN
      .stall_cycles (stall_cycles),
`endif
      .bus          (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // operand memory image: lane i = addr+i, scalar = addr[3:0]+1
   function automatic logic [W*SZ-1:0] mem_a(input logic [AW-1:0] addr);
      logic [W*SZ-1:0] v;
      v = '0;
      for (int i = 0; i < SZ; i++) v[i*W +: W] = addr + 8'(i);
      return v;
   endfunction

   function automatic logic [W*SZ-1:0] exp_sum(input logic [AW-1:0] b0);
      logic [W*SZ-1:0] s;
      logic [7:0] ad, bb, ln;
      s = '0;
      for (int j = 0; j < 3; j++) begin
         ad = b0 + 8'(j);
         bb = {4'h0, ad[3:0]} + 8'd1;
         for (int i = 0; i < SZ; i++) begin
            ln = ad + 8'(i);
            s[i*W +: W] = s[i*W +: W] + ln * bb;
         end
      end
      return s;
   endfunction

   assign bus.rd_a     = mem_a(bus.rd_addr);
   assign bus.rd_b     = {4'h0, bus.rd_addr[3:0]} + 8'd1;
   assign bus.rd_valid = bus.rd_en && (wcnt >= lat);
   assign bus.mac_out  = acc;

   always @(posedge clk) begin
      if (!bus.rd_en || bus.rd_valid) wcnt <= 0;
      else                            wcnt <= wcnt + 1;
   end

   // vsmac array model: output register updates on the falling edge
   always @(negedge clk) begin
      if (bus.mac_clear) acc <= '0;
      else if (bus.mac_enable)
         for (int i = 0; i < SZ; i++)
            acc[i*W +: W] <= acc[i*W +: W] + bus.mac_a[i*W +: W] * bus.mac_b;
   end

   initial begin
      n_en = 0; n_dbl = 0; n_addr = 0; en_prev = 1'b0; wcnt = 0;
   end

   always @(posedge clk) begin
      if (bus.mac_enable) n_en <= n_en + 1;
      if (bus.mac_enable && en_prev) n_dbl <= n_dbl + 1;
      en_prev <= bus.mac_enable;
      if (!reset && bus.rd_en && bus.rd_valid) begin
         addr_log[n_addr % 64] <= bus.rd_addr;
         n_addr <= n_addr + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [AW-1:0] b);
      bus.base_addr = b;
      bus.start     = 1'b1;
      tick();
      bus.start     = 1'b0;
   endtask

   task automatic wait_res(input string tag);
      int n;
      n = 0;
      while (!bus.res_valid && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_res_valid"}, 64'(bus.res_valid), 64'd1);
   endtask

   task automatic run_job(input logic [AW-1:0] b, input string tag);
      do_start(b);
      wait_res(tag);
      check({tag, "_res_data"}, 64'(bus.res_data), 64'(exp_sum(b)));
      tick();
      check({tag, "_done"}, 64'(bus.done), 64'd1);
   endtask

   task automatic check_addrs(input string tag, input logic [AW-1:0] a0);
      int b;
      logic [AW-1:0] a;
      b = n_addr - 3;
      for (int j = 0; j < 3; j++) begin
         a = a0 + 8'(j);
         check({tag, "_rd_addr"}, 64'(addr_log[(b + j) % 64]), 64'(a));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      logic [W*SZ-1:0] d0;
      logic saw_done;
      n_checks = 0; n_pass = 0; lat = 0;
      reset = 1'b1; bus.start = 1'b0; bus.base_addr = '0; bus.res_ready = 1'b1;
      repeat (2) tick();

      check("rst_mac_clear", 64'(bus.mac_clear), 64'd1);
      check("rst_busy",      64'(bus.busy),      64'd0);
      check("rst_rd_en",     64'(bus.rd_en),     64'd0);
      check("rst_res_valid", 64'(bus.res_valid), 64'd0);
      check("rst_done",      64'(bus.done),      64'd0);
      check("rst_rd_addr",   64'(bus.rd_addr),   64'd0);
      check("rst_res_data",  64'(bus.res_data),  64'd0);
      reset = 1'b0;
      tick();
      check("clear_released", 64'(bus.mac_clear), 64'd0);

      // nominal job, latency measured from the start cycle
      e0 = n_en;
      bus.base_addr = 8'h10;
      bus.start     = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         bus.start = 1'b0;
         if (c == 1) check("clear_pulse", 64'(bus.mac_clear), 64'd1);
         if (c == 2) begin
            check("clear_one_cycle", 64'(bus.mac_clear), 64'd0);
            check("first_rd_en",     64'(bus.rd_en),     64'd1);
         end
         if (c == 9) check("res_valid_early", 64'(bus.res_valid), 64'd0);
      end
      check("latency_res_valid", 64'(bus.res_valid), 64'd1);
      check("nominal_res_data", 64'(bus.res_data), 64'h0000_8680_7A74_6E68);
      tick();
      check("nominal_done",      64'(bus.done),      64'd1);
      check("nominal_valid_drop", 64'(bus.res_valid), 64'd0);
      check("nominal_idle",      64'(bus.busy),      64'd0);
      tick();
      check("done_one_cycle", 64'(bus.done), 64'd0);
      check_addrs("nominal", 8'h10);
      check("nominal_enables", 64'(n_en - e0), 64'd3);

      // address wrap
      e0 = n_en;
      run_job(8'hFE, "wrap");
      check_addrs("wrap", 8'hFE);
      check("wrap_enables", 64'(n_en - e0), 64'd3);

      // result backpressure
      bus.res_ready = 1'b0;
      do_start(8'h30);
      wait_res("bp");
      d0 = bus.res_data;
      saw_done = 1'b0;
      repeat (5) begin
         tick();
         if (bus.done) saw_done = 1'b1;
      end
      check("bp_valid_held", 64'(bus.res_valid), 64'd1);
      check("bp_data_held",  64'(bus.res_data),  64'(d0));
      check("bp_data",       64'(bus.res_data),  64'(exp_sum(8'h30)));
      check("bp_no_done",    64'(saw_done),      64'd0);
      bus.res_ready = 1'b1;
      tick();
      check("bp_done",       64'(bus.done),      64'd1);
      check("bp_valid_drop", 64'(bus.res_valid), 64'd0);

      // start rules: ignored mid-job, accepted in the done cycle
      do_start(8'h40);
      tick();
      bus.base_addr = 8'h99;
      bus.start     = 1'b1;
      tick();
      bus.start     = 1'b0;
      check("ign_start_busy",  64'(bus.busy),      64'd1);
      check("ign_start_clear", 64'(bus.mac_clear), 64'd0);
      wait_res("ign");
      check("ign_res_data", 64'(bus.res_data), 64'(exp_sum(8'h40)));
      tick();
      check("ign_done", 64'(bus.done), 64'd1);
      do_start(8'h50);
      check("done_cycle_start_clear", 64'(bus.mac_clear), 64'd1);
      check("done_cycle_start_busy",  64'(bus.busy),      64'd1);
      wait_res("restart");
      check("restart_res_data", 64'(bus.res_data), 64'(exp_sum(8'h50)));
      tick();

      // reset during the second fetch, with rd_valid in the same cycle
      do_start(8'h60);
      repeat (3) tick();
      check("mid_rd_addr", 64'(bus.rd_addr), 64'h61);
      reset = 1'b1;
      tick();
      check("mid_rst_busy",       64'(bus.busy),       64'd0);
      check("mid_rst_rd_en",      64'(bus.rd_en),      64'd0);
      check("mid_rst_mac_enable", 64'(bus.mac_enable), 64'd0);
      check("mid_rst_mac_a",      64'(bus.mac_a),      64'd0);
      check("mid_rst_mac_b",      64'(bus.mac_b),      64'd0);
      check("mid_rst_rd_addr",    64'(bus.rd_addr),    64'd0);
      check("mid_rst_mac_clear",  64'(bus.mac_clear),  64'd1);
      reset = 1'b0;
      tick();
      run_job(8'h20, "post_rst");
      check_addrs("post_rst", 8'h20);

`ifdef VSMAC_CTRL_STALL_CNT_EN
      lat = 2;
      do_start(8'h70);
      check("stall_clr_on_start", 64'(stall_cycles), 64'd0);
      wait_res("stall");
      tick();
      check("stall_at_done", 64'(stall_cycles), 64'd6);
      repeat (3) tick();
      check("stall_hold_idle", 64'(stall_cycles), 64'd6);
      lat = 0;
      do_start(8'h71);
      check("stall_cleared", 64'(stall_cycles), 64'd0);
      wait_res("stall2");
      tick();
`endif

      check("no_double_enable", 64'(n_dbl), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

`default_nettype wire
